// File: rtl/ring_step_scheduler.sv
// Sequencing controller for a one-hot ring counter: prescaled step enables,
// free-run / burst / single-step / pause / resync modes, slot index mirror.
module ring_step_scheduler #(
    parameter int PRESC_W = 24,
    parameter int NUM_POS = 5,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               step,
    input  logic               burst_go,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [PRESC_W-1:0] period,
    input  logic               resync,
    output logic               step_en,
    output logic               ring_rst_n,
    output logic [2:0]         pos,
    output logic               lap_done,
    output logic               burst_done,
    output logic               busy,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BURST = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    // Terminal prescaler count; periods 0 and 1 both tick every clock.
    function automatic logic [PRESC_W-1:0] tick_limit(input logic [PRESC_W-1:0] per);
        if (per < PRESC_W'(2)) begin
            tick_limit = {PRESC_W{1'b0}};
        end else begin
            tick_limit = per - PRESC_W'(1);
        end
    endfunction

    function automatic logic [2:0] next_pos(input logic [2:0] p);
        if (p == 3'(NUM_POS - 1)) begin
            next_pos = 3'd0;
        end else begin
            next_pos = p + 3'd1;
        end
    endfunction

    state_t             state_r, state_s;
    logic [PRESC_W-1:0] cnt_r, cnt_s;
    logic [BURST_W-1:0] rem_r, rem_s;
    logic               saved_burst_r, saved_burst_s;
    logic               step_en_r, step_en_s;
    logic               ring_rst_n_r, ring_rst_n_s;
    logic [2:0]         pos_r, pos_s;
    logic               lap_done_r, lap_done_s;
    logic               burst_done_r, burst_done_s;
    logic               busy_r, busy_s;
    logic               run_s;
    logic               burst_mode_s;
    logic [PRESC_W-1:0] limit_s;

    // Command decode, prescaler and burst accounting for the next edge.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        rem_s         = rem_r;
        saved_burst_s = saved_burst_r;
        step_en_s     = 1'b0;
        ring_rst_n_s  = 1'b1;
        burst_done_s  = 1'b0;
        run_s         = 1'b0;
        burst_mode_s  = 1'b0;
        limit_s       = tick_limit(period);
        pos_s         = step_en_r ? next_pos(pos_r) : pos_r;

        if (resync) begin
            ring_rst_n_s = 1'b0;
            pos_s        = 3'd0;
            cnt_s        = {PRESC_W{1'b0}};
        end else if (stop) begin
            state_s = ST_IDLE;
            cnt_s   = {PRESC_W{1'b0}};
            rem_s   = {BURST_W{1'b0}};
        end else if (pause) begin
            case (state_r)
                ST_RUN: begin
                    state_s       = ST_PAUSE;
                    saved_burst_s = 1'b0;
                end
                ST_BURST: begin
                    state_s       = ST_PAUSE;
                    saved_burst_s = 1'b1;
                end
                default: begin
                end
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (burst_go && (burst_len != {BURST_W{1'b0}})) begin
                        state_s = ST_BURST;
                        rem_s   = burst_len;
                        cnt_s   = {PRESC_W{1'b0}};
                    end else if (start) begin
                        state_s = ST_RUN;
                        cnt_s   = {PRESC_W{1'b0}};
                    end else if (step) begin
                        step_en_s = 1'b1;
                    end else begin
                    end
                end
                ST_RUN: begin
                    run_s = 1'b1;
                end
                ST_BURST: begin
                    run_s        = 1'b1;
                    burst_mode_s = 1'b1;
                end
                ST_PAUSE: begin
                    // Resume edge already counts: the frozen cnt advances on this edge.
                    if (start) begin
                        state_s      = saved_burst_r ? ST_BURST : ST_RUN;
                        run_s        = 1'b1;
                        burst_mode_s = saved_burst_r;
                    end else if (step) begin
                        step_en_s = 1'b1;
                    end else begin
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        if (run_s) begin
            if (burst_mode_s && (rem_r == {BURST_W{1'b0}})) begin
                state_s      = ST_IDLE;
                cnt_s        = {PRESC_W{1'b0}};
                burst_done_s = 1'b1;
            end else if (cnt_r >= limit_s) begin
                cnt_s     = {PRESC_W{1'b0}};
                step_en_s = 1'b1;
                if (burst_mode_s) begin
                    rem_s = rem_r - BURST_W'(1);
                end else begin
                    rem_s = rem_r;
                end
            end else begin
                cnt_s = cnt_r + PRESC_W'(1);
            end
        end else begin
        end

        // pos_s is the slot the issued step will move away from.
        lap_done_s = step_en_s && (pos_s == 3'(NUM_POS - 1));
        busy_s     = (state_s == ST_RUN) || (state_s == ST_BURST);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {PRESC_W{1'b0}};
            rem_r         <= {BURST_W{1'b0}};
            saved_burst_r <= 1'b0;
            step_en_r     <= 1'b0;
            ring_rst_n_r  <= 1'b0;
            pos_r         <= 3'd0;
            lap_done_r    <= 1'b0;
            burst_done_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            rem_r         <= rem_s;
            saved_burst_r <= saved_burst_s;
            step_en_r     <= step_en_s;
            ring_rst_n_r  <= ring_rst_n_s;
            pos_r         <= pos_s;
            lap_done_r    <= lap_done_s;
            burst_done_r  <= burst_done_s;
            busy_r        <= busy_s;
        end
    end

    assign step_en    = step_en_r;
    assign ring_rst_n = ring_rst_n_r;
    assign pos        = pos_r;
    assign lap_done   = lap_done_r;
    assign burst_done = burst_done_r;
    assign busy       = busy_r;
    assign state      = state_r;

endmodule

// File: tb/tb_ring_step_scheduler.sv
// Scoreboard bench for ring_step_scheduler: expected step_en / burst_done events
// are queued by the stimulus and matched by an independent negedge monitor.
module tb_ring_step_scheduler;

    localparam int PRESC_W = 24;
    localparam int NUM_POS = 5;
    localparam int BURST_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0, stop = 1'b0, pause = 1'b0, step = 1'b0;
    logic               burst_go = 1'b0, resync = 1'b0;
    logic [BURST_W-1:0] burst_len = 8'd0;
    logic [PRESC_W-1:0] period = 24'd0;
    logic               step_en, ring_rst_n, lap_done, burst_done, busy;
    logic [2:0]         pos;
    logic [1:0]         state;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int mpos = 0;

    typedef struct {
        int   cyc;
        int   pos;
        logic lap;
    } step_exp_t;

    step_exp_t exp_q[$];
    int        bd_q[$];
    step_exp_t e_mon;
    int        bd_mon;

    ring_step_scheduler #(.PRESC_W(PRESC_W), .NUM_POS(NUM_POS), .BURST_W(BURST_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .step(step), .burst_go(burst_go), .burst_len(burst_len), .period(period),
        .resync(resync), .step_en(step_en), .ring_rst_n(ring_rst_n), .pos(pos),
        .lap_done(lap_done), .burst_done(burst_done), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: queue a step at edge c and advance the bench's slot model.
    task automatic exp_step(input int c);
        step_exp_t s;
        s.cyc = c;
        s.pos = mpos;
        s.lap = (mpos == NUM_POS - 1);
        exp_q.push_back(s);
        mpos = (mpos + 1) % NUM_POS;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_cmd(input int sel, input logic v);
        case (sel)
            0: start = v;
            1: stop = v;
            2: pause = v;
            3: step = v;
            4: burst_go = v;
            default: resync = v;
        endcase
    endtask

    // Pulse command sel so that it is sampled at rising edge e.
    task automatic pulse(input int sel, input int e);
        wait_until(e - 1);
        set_cmd(sel, 1'b1);
        @(negedge clk);
        set_cmd(sel, 1'b0);
    endtask

    // Monitor: match every step_en / burst_done against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL step_missing: got no step_en expected one at cyc %0d", exp_q[0].cyc);
                e_mon = exp_q.pop_front();
            end
            while (bd_q.size() > 0 && bd_q[0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL burst_done_missing: got no pulse expected one at cyc %0d", bd_q[0]);
                bd_mon = bd_q.pop_front();
            end
            if (step_en) begin
                checks++;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e_mon = exp_q.pop_front();
                    chk("step_pos", pos, e_mon.pos);
                    chk("step_lap", lap_done, e_mon.lap);
                end else begin
                    failures++;
                    $display("FAIL step_unexpected: got step_en=1 expected 0 at cyc %0d", cyc);
                end
                chk("step_vs_ring_rst", ring_rst_n, 1'b1);
            end else if (lap_done) begin
                checks++;
                failures++;
                $display("FAIL lap_without_step: got lap_done=1 expected 0 at cyc %0d", cyc);
            end
            if (burst_done) begin
                checks++;
                if (bd_q.size() > 0 && bd_q[0] == cyc) begin
                    bd_mon = bd_q.pop_front();
                end else begin
                    failures++;
                    $display("FAIL burst_done_unexpected: got 1 expected 0 at cyc %0d", cyc);
                end
            end
        end
    end

    initial begin
        int k;
        int b;
        period = 24'd4;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_state", state, 2'd0);
        chk("rst_step_en", step_en, 1'b0);
        chk("rst_ring_rst_n", ring_rst_n, 1'b0);
        chk("rst_pos", pos, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lap", lap_done, 1'b0);
        chk("rst_burst_done", burst_done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ring_rst_n", ring_rst_n, 1'b1);
        chk("rel_state", state, 2'd0);

        // Free run, period 4: five steps, lap on the fifth
        k = cyc + 1;
        for (int i = 1; i <= 5; i++) exp_step(k + 4 * i);
        pulse(0, k);
        chk("run_state", state, 2'd1);
        chk("run_busy", busy, 1'b1);
        pulse(1, k + 23);
        chk("run_stop_state", state, 2'd0);
        chk("run_stop_busy", busy, 1'b0);
        chk("run_pos_wrapped", pos, 3'd0);

        // Burst of 3 at period 2
        period = 24'd2;
        burst_len = 8'd3;
        b = cyc + 1;
        exp_step(b + 2);
        exp_step(b + 4);
        exp_step(b + 6);
        bd_q.push_back(b + 7);
        pulse(4, b);
        chk("burst_state", state, 2'd2);
        chk("burst_busy", busy, 1'b1);
        wait_until(b + 7);
        chk("burst_end_state", state, 2'd0);
        chk("burst_end_busy", busy, 1'b0);
        chk("burst_end_pos", pos, 3'd3);

        // Pause at cnt=6, hold 20 clocks, resume -> tick 3 clocks later
        period = 24'd10;
        k = cyc + 1;
        pulse(0, k);
        pulse(2, k + 7);
        chk("pause_state", state, 2'd3);
        chk("pause_busy", busy, 1'b0);
        exp_step(k + 30);
        exp_step(k + 40);
        pulse(0, k + 27);
        chk("resume_state", state, 2'd1);
        pulse(1, k + 42);
        chk("pause_stop_state", state, 2'd0);

        // Seven single steps spaced 3 clocks
        mpos = 0;
        b = cyc + 1;
        for (int i = 0; i < 7; i++) begin
            exp_step(b + 3 * i);
            pulse(3, b + 3 * i);
        end
        wait_until(b + 20);
        chk("single_pos", pos, 3'd2);
        chk("single_state", state, 2'd0);

        // Resync coincident with a due tick at pos 3
        period = 24'd4;
        k = cyc + 1;
        exp_step(k + 4);
        pulse(0, k);
        chk("pre_resync_state", state, 2'd1);
        wait_until(k + 6);
        chk("pre_resync_pos", pos, 3'd3);
        pulse(5, k + 8);
        chk("resync_ring_rst_n", ring_rst_n, 1'b0);
        chk("resync_step_en", step_en, 1'b0);
        chk("resync_pos", pos, 3'd0);
        chk("resync_state", state, 2'd1);
        mpos = 0;
        exp_step(k + 12);
        @(negedge clk);
        chk("resync_release", ring_rst_n, 1'b1);
        pulse(1, k + 14);
        chk("resync_stop_state", state, 2'd0);

        // Async reset mid-burst with 5 steps remaining
        period = 24'd3;
        burst_len = 8'd8;
        b = cyc + 1;
        exp_step(b + 3);
        exp_step(b + 6);
        exp_step(b + 9);
        pulse(4, b);
        wait_until(b + 10);
        rst_n = 1'b0;
        #1;
        chk("arst_state", state, 2'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ring_rst_n", ring_rst_n, 1'b0);
        chk("arst_pos", pos, 3'd0);
        chk("arst_step_en", step_en, 1'b0);
        chk("arst_burst_done", burst_done, 1'b0);
        mpos = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_ring_rst_n", ring_rst_n, 1'b1);
        chk("arst_rel_state", state, 2'd0);
        repeat (10) @(negedge clk);
        chk("arst_idle_state", state, 2'd0);

        // burst_len 0 is ignored
        burst_len = 8'd0;
        b = cyc + 1;
        pulse(4, b);
        chk("burst0_state", state, 2'd0);
        chk("burst0_busy", busy, 1'b0);
        repeat (5) @(negedge clk);

        // period 0 and 1 both step every clock
        for (int p = 0; p < 2; p++) begin
            period = PRESC_W'(p);
            k = cyc + 1;
            exp_step(k + 1);
            exp_step(k + 2);
            pulse(0, k);
            pulse(1, k + 3);
            chk("fast_stop_state", state, 2'd0);
            chk("fast_pos", pos, 32'(mpos));
            repeat (3) @(negedge clk);
        end

        // start and burst_go together: burst wins
        period = 24'd2;
        burst_len = 8'd1;
        b = cyc + 1;
        exp_step(b + 2);
        bd_q.push_back(b + 3);
        wait_until(b - 1);
        start = 1'b1;
        burst_go = 1'b1;
        @(negedge clk);
        start = 1'b0;
        burst_go = 1'b0;
        chk("coincide_state", state, 2'd2);
        wait_until(b + 4);
        chk("coincide_end_state", state, 2'd0);

        repeat (5) @(negedge clk);
        chk("step_queue_empty", exp_q.size(), 0);
        chk("bd_queue_empty", bd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
